// File: rtl/bf_decoder_adaptive.sv
// Serial QC-MDPC bit-flipping decoder with fixed or syndrome-weight-adaptive
// thresholds, incremental syndrome-weight tracking, early exit on a clear
// syndrome and stall detection when a full sweep flips nothing.
module bf_decoder_adaptive #(
    parameter int R       = 127,
    parameter int W       = 5,
    parameter int POS_W   = 8,
    parameter int MAX_IT  = 10,
    parameter int A_NUM   = 1,
    parameter int A_SHIFT = 3,
    parameter int B_OFF   = 1,
    parameter int TMIN    = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         thr_mode,
    input  logic [$clog2(W+1)-1:0]       cfg_thr,
    input  logic [R-1:0]                 s_in,
    input  logic [W*POS_W-1:0]           h0_pos_flat,
    input  logic [W*POS_W-1:0]           h1_pos_flat,
    output logic [R-1:0]                 e0,
    output logic [R-1:0]                 e1,
    output logic                         busy,
    output logic                         done,
    output logic                         success,
    output logic [$clog2(MAX_IT+1)-1:0]  iter_count,
    output logic [$clog2(R+1)-1:0]       syn_weight
);

    localparam int CNT_W = $clog2(W + 1);
    localparam int IDX_W = $clog2(R);
    localparam int K_W   = (W > 1) ? $clog2(W) : 1;
    localparam int IT_W  = $clog2(MAX_IT + 1);
    localparam int SW_W  = $clog2(R + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_THRESH, S_VOTE, S_DECIDE, S_UPDATE, S_NEXT, S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [R-1:0]       syn_q, syn_d;
    logic [R-1:0]       e0_q, e0_d, e1_q, e1_d;
    logic [IDX_W-1:0]   i_q, i_d;
    logic [K_W-1:0]     k_q, k_d;
    logic [CNT_W-1:0]   upc0_q, upc0_d, upc1_q, upc1_d;
    logic [CNT_W-1:0]   thr_q, thr_d;
    logic [CNT_W-1:0]   cfg_thr_q, cfg_thr_d;
    logic               mode_q, mode_d;
    logic               flip0_q, flip0_d, flip1_q, flip1_d;
    logic               any_flip_q, any_flip_d;
    logic [IT_W-1:0]    iter_q, iter_d;
    logic [SW_W-1:0]    weight_q, weight_d;
    logic               success_q, success_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [IDX_W-1:0]   idx0, idx1;

    // Circular index i + pos, wrapped with a single conditional subtract.
    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] i,
                                                  input logic [POS_W-1:0] p);
        logic [POS_W:0] sum;
        sum = {1'b0, p} + (POS_W+1)'(i);
        if (sum >= (POS_W+1)'(R)) sum = sum - (POS_W+1)'(R);
        return IDX_W'(sum);
    endfunction

    // Syndrome positions touched by the current (i, k) pair for both halves.
    always_comb begin
        idx0 = wrap_idx(i_q, h0_pos_flat[k_q*POS_W +: POS_W]);
        idx1 = wrap_idx(i_q, h1_pos_flat[k_q*POS_W +: POS_W]);
    end

    // Next-state and datapath logic for the decoding FSM.
    always_comb begin
        logic [31:0]     t_raw;
        logic [SW_W-1:0] pop;
        logic [SW_W-1:0] w_new;
        // NOTE: every variable gets its default first, so no path can infer a latch.
        state_d    = state_q;
        syn_d      = syn_q;
        e0_d       = e0_q;
        e1_d       = e1_q;
        i_d        = i_q;
        k_d        = k_q;
        upc0_d     = upc0_q;
        upc1_d     = upc1_q;
        thr_d      = thr_q;
        cfg_thr_d  = cfg_thr_q;
        mode_d     = mode_q;
        flip0_d    = flip0_q;
        flip1_d    = flip1_q;
        any_flip_d = any_flip_q;
        iter_d     = iter_q;
        weight_d   = weight_q;
        success_d  = success_q;
        done_d     = 1'b0;
        t_raw      = '0;
        pop        = '0;
        w_new      = weight_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    for (int b = 0; b < R; b++) pop = pop + SW_W'(s_in[b]);
                    syn_d     = s_in;
                    weight_d  = pop;
                    mode_d    = thr_mode;
                    cfg_thr_d = cfg_thr;
                    e0_d      = '0;
                    e1_d      = '0;
                    iter_d    = '0;
                    success_d = 1'b0;
                    state_d   = S_THRESH;
                end
            end
            S_THRESH: begin
                if (weight_q == '0) begin
                    success_d = 1'b1;
                    state_d   = S_DONE;
                end else if (iter_q == IT_W'(MAX_IT) || (iter_q != '0 && !any_flip_q)) begin
                    success_d = 1'b0;
                    state_d   = S_DONE;
                end else begin
                    if (mode_q)
                        t_raw = ((32'(weight_q) * 32'(A_NUM)) >> A_SHIFT) + 32'(B_OFF);
                    else
                        t_raw = 32'(cfg_thr_q);
                    if (t_raw < 32'(TMIN))   t_raw = 32'(TMIN);
                    else if (t_raw > 32'(W)) t_raw = 32'(W);
                    thr_d      = CNT_W'(t_raw);
                    iter_d     = iter_q + 1'b1;
                    i_d        = '0;
                    k_d        = '0;
                    any_flip_d = 1'b0;
                    state_d    = S_VOTE;
                end
            end
            S_VOTE: begin
                upc0_d = ((k_q == '0) ? '0 : upc0_q) + CNT_W'(syn_q[idx0]);
                upc1_d = ((k_q == '0) ? '0 : upc1_q) + CNT_W'(syn_q[idx1]);
                if (k_q == K_W'(W - 1)) begin
                    k_d     = '0;
                    state_d = S_DECIDE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_DECIDE: begin
                flip0_d = (upc0_q >= thr_q);
                flip1_d = (upc1_q >= thr_q);
                if (flip0_d || flip1_d) begin
                    if (flip0_d) e0_d[i_q] = ~e0_q[i_q];
                    if (flip1_d) e1_d[i_q] = ~e1_q[i_q];
                    any_flip_d = 1'b1;
                    k_d        = '0;
                    state_d    = S_UPDATE;
                end else begin
                    state_d = S_NEXT;
                end
            end
            S_UPDATE: begin
                if (flip0_q) syn_d[idx0] = ~syn_q[idx0];
                if (flip1_q) syn_d[idx1] = ~syn_q[idx1];
                // NOTE: blocking here on purpose: the second adjustment builds on the first.
                if (!(flip0_q && flip1_q && idx0 == idx1)) begin
                    if (flip0_q) w_new = syn_q[idx0] ? w_new - 1'b1 : w_new + 1'b1;
                    if (flip1_q) w_new = syn_q[idx1] ? w_new - 1'b1 : w_new + 1'b1;
                end
                weight_d = w_new;
                if (k_q == K_W'(W - 1)) begin
                    k_d     = '0;
                    state_d = S_NEXT;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_NEXT: begin
                if (weight_q == '0) begin
                    success_d = 1'b1;
                    state_d   = S_DONE;
                end else if (i_q == IDX_W'(R - 1)) begin
                    state_d = S_THRESH;
                end else begin
                    i_d     = i_q + 1'b1;
                    k_d     = '0;
                    state_d = S_VOTE;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: syndrome and error vectors are reset too, so an aborted decode leaves no residue.
            state_q    <= S_IDLE;
            syn_q      <= '0;
            e0_q       <= '0;
            e1_q       <= '0;
            i_q        <= '0;
            k_q        <= '0;
            upc0_q     <= '0;
            upc1_q     <= '0;
            thr_q      <= '0;
            cfg_thr_q  <= '0;
            mode_q     <= 1'b0;
            flip0_q    <= 1'b0;
            flip1_q    <= 1'b0;
            any_flip_q <= 1'b0;
            iter_q     <= '0;
            weight_q   <= '0;
            success_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            syn_q      <= syn_d;
            e0_q       <= e0_d;
            e1_q       <= e1_d;
            i_q        <= i_d;
            k_q        <= k_d;
            upc0_q     <= upc0_d;
            upc1_q     <= upc1_d;
            thr_q      <= thr_d;
            cfg_thr_q  <= cfg_thr_d;
            mode_q     <= mode_d;
            flip0_q    <= flip0_d;
            flip1_q    <= flip1_d;
            any_flip_q <= any_flip_d;
            iter_q     <= iter_d;
            weight_q   <= weight_d;
            success_q  <= success_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign e0         = e0_q;
    assign e1         = e1_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign success    = success_q;
    assign iter_count = iter_q;
    assign syn_weight = weight_q;

endmodule

// File: tb/tb_bf_decoder_adaptive.sv
// Directed bench for bf_decoder_adaptive on a small R=11, W=3 code.
module tb_bf_decoder_adaptive;

    localparam int R       = 11;
    localparam int W       = 3;
    localparam int POS_W   = 4;
    localparam int MAX_IT  = 10;
    localparam int BUDGET  = 200;

    // Cycles from start edge to done: 1 THRESH + positions + 1 DONE.
    localparam int LAT_ZERO  = 2;
    localparam int LAT_BIT2  = 1 + 2*(W+2) + (2*W+2) + 1;   // early exit at i=2
    localparam int LAT_STALL = 1 + R*(W+2) + 1 + 1;         // one sweep, then stall

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic                  thr_mode;
    logic [1:0]            cfg_thr;
    logic [R-1:0]          s_in;
    logic [W*POS_W-1:0]    h0_pos_flat;
    logic [W*POS_W-1:0]    h1_pos_flat;
    logic [R-1:0]          e0, e1;
    logic                  busy, done, success;
    logic [3:0]            iter_count;
    logic [3:0]            syn_weight;

    int checks   = 0;
    int failures = 0;

    bf_decoder_adaptive #(
        .R(R), .W(W), .POS_W(POS_W), .MAX_IT(MAX_IT),
        .A_NUM(1), .A_SHIFT(0), .B_OFF(0), .TMIN(2)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .thr_mode(thr_mode), .cfg_thr(cfg_thr),
        .s_in(s_in), .h0_pos_flat(h0_pos_flat), .h1_pos_flat(h1_pos_flat),
        .e0(e0), .e1(e1), .busy(busy), .done(done), .success(success),
        .iter_count(iter_count), .syn_weight(syn_weight)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Launch one decode and return the cycles from the start edge to done.
    // glitch_at > 0 pulses a bogus start on that cycle while the decode is running.
    task automatic run(input string tag, input logic mode, input logic [1:0] thr,
                       input logic [R-1:0] s, input int exp_w0, input int glitch_at,
                       output int n);
        @(negedge clk);
        start    = 1'b1;
        thr_mode = mode;
        cfg_thr  = thr;
        s_in     = s;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, "_busy_rise"}, 32'(busy), 32'd1);
        check({tag, "_w0"}, 32'(syn_weight), 32'(exp_w0));
        n = 1;
        forever begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) break;
            if (n == glitch_at) begin
                start    = 1'b1;
                s_in     = 11'h7FF;
                thr_mode = ~mode;
                cfg_thr  = 2'd2;
            end
            n++;
            if (n > BUDGET) begin
                check({tag, "_timeout"}, 32'(n), 32'(BUDGET));
                break;
            end
        end
    endtask

    task automatic check_result(input string tag, input int n, input int exp_n,
                                input logic [R-1:0] exp_e0, input logic [R-1:0] exp_e1,
                                input logic exp_succ, input int exp_it, input int exp_w);
        check({tag, "_latency"}, 32'(n), 32'(exp_n));
        check({tag, "_e0"}, 32'(e0), 32'(exp_e0));
        check({tag, "_e1"}, 32'(e1), 32'(exp_e1));
        check({tag, "_success"}, 32'(success), 32'(exp_succ));
        check({tag, "_iter"}, 32'(iter_count), 32'(exp_it));
        check({tag, "_weight"}, 32'(syn_weight), 32'(exp_w));
        check({tag, "_busy_fall"}, 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_success_hold"}, 32'(success), 32'(exp_succ));
    endtask

    initial begin
        int n;
        int seen_done;
        rst         = 1'b1;
        start       = 1'b0;
        thr_mode    = 1'b0;
        cfg_thr     = 2'd0;
        s_in        = '0;
        h0_pos_flat = {4'd3, 4'd1, 4'd0};
        h1_pos_flat = {4'd5, 4'd2, 4'd0};
        repeat (2) @(posedge clk);
        #1;
        check("rst_e0", 32'(e0), 32'd0);
        check("rst_e1", 32'(e1), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_success", 32'(success), 32'd0);
        check("rst_iter", 32'(iter_count), 32'd0);
        check("rst_weight", 32'(syn_weight), 32'd0);
        rst = 1'b0;

        // Zero syndrome: immediate success.
        run("zero", 1'b0, 2'd3, 11'h000, 0, 0, n);
        check_result("zero", n, LAT_ZERO, 11'h000, 11'h000, 1'b1, 0, 0);

        // Single error at e0 bit 2 gives syndrome bits 2,3,5; fixed T=3.
        run("fixed", 1'b0, 2'd3, 11'h02C, 3, 0, n);
        check_result("fixed", n, LAT_BIT2, 11'h004, 11'h000, 1'b1, 1, 0);

        // Adaptive: T = weight 3, clamped to W=3; cfg_thr deliberately useless.
        run("adapt", 1'b1, 2'd0, 11'h02C, 3, 0, n);
        check_result("adapt", n, LAT_BIT2, 11'h004, 11'h000, 1'b1, 1, 0);

        // Weight-1 syndrome never reaches T=3: one sweep, then stall.
        run("stall", 1'b0, 2'd3, 11'h001, 1, 0, n);
        check_result("stall", n, LAT_STALL, 11'h000, 11'h000, 1'b0, 1, 1);

        // Reset during UPDATE (cycles 15..17 after start) aborts with no done.
        @(negedge clk);
        start    = 1'b1;
        thr_mode = 1'b0;
        cfg_thr  = 2'd3;
        s_in     = 11'h02C;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_e0", 32'(e0), 32'd0);
        check("abort_iter", 32'(iter_count), 32'd0);
        check("abort_weight", 32'(syn_weight), 32'd0);
        seen_done = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (done || busy) seen_done++;
        end
        check("abort_quiet", 32'(seen_done), 32'd0);

        run("rerun", 1'b0, 2'd3, 11'h02C, 3, 0, n);
        check_result("rerun", n, LAT_BIT2, 11'h004, 11'h000, 1'b1, 1, 0);

        // Bogus start pulses mid-decode must change nothing.
        run("glitch", 1'b0, 2'd3, 11'h02C, 3, 5, n);
        check_result("glitch", n, LAT_BIT2, 11'h004, 11'h000, 1'b1, 1, 0);
        run("glitch2", 1'b0, 2'd3, 11'h02C, 3, 16, n);
        check_result("glitch2", n, LAT_BIT2, 11'h004, 11'h000, 1'b1, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
